rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- In-order retire buffer; the other end of rename.
- Rename allocates a physical destination per instruction. This block records each allocation in program order, marks entries done from the CDB, and retires them in order.
- On retire, returns the displaced (previous) physical register to the free list: free_en_o/free_addr_o drive reg_free_en_i/reg_free_addr_i.
- Sits between rename/dispatch and the free list.

Parameters:
- DEPTH, 16, number of in-flight entries (power of 2, ≥2).
- IDXW, 4, entry index width (log2 DEPTH).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- alloc_en_i  in  1  rename pushes one instruction this cycle.
- alloc_has_rd_i  in  1  instruction writes a destination.
- alloc_rd_addr_i  in  5  architectural destination.
- alloc_prd_i  in  5  newly allocated physical destination.
- alloc_old_prd_i  in  5  previous RAT mapping of rd, to be freed at retire.
- alloc_ready_o  out  1  entry available; alloc_en_i is honoured only when high.
- alloc_idx_o  out  IDXW  index the next accepted allocation gets (tail).
- cdb_en_i  in  1  completion broadcast.
- cdb_idx_i  in  IDXW  entry index completing.
- commit_stall_i  in  1  inhibit retirement this cycle.
- commit_en_o  out  1  one instruction retired (registered).
- commit_rd_addr_o  out  5  its architectural rd.
- commit_prd_o  out  5  its physical rd (architectural-state update).
- free_en_o  out  1  release a physical register (registered).
- free_addr_o  out  5  register released.
- count_o  out  IDXW+1  occupied entries.
- empty_o  out  1  count_o == 0.

Behaviour:
- State per entry: valid, done, has_rd, rd[4:0], prd[4:0], old_prd[4:0]. Also head and tail (IDXW bits, wrap mod DEPTH) and count (IDXW+1 bits).
- Reset (reset_i low, async): all valid/done cleared; head=tail=0; count=0.
- Output reset values: commit_en_o=0, free_en_o=0, commit_rd_addr_o=0, commit_prd_o=0, free_addr_o=0, alloc_ready_o=1, alloc_idx_o=0, count_o=0, empty_o=1.
- Reset mid-operation discards all in-flight entries; no frees are issued for them.
- alloc_ready_o = (count < DEPTH). There is no same-cycle retire bypass: when full, alloc is refused even if a retire occurs that cycle.
- Allocate (alloc_en_i & alloc_ready_o) at the edge:
  - entry[tail] written with valid=1, done=0, and the fields.
  - tail <= tail+1, wrapping DEPTH-1 -> 0.
  - alloc_en_i while alloc_ready_o=0 is ignored; no state change.
- Complete (cdb_en_i) at the edge: done[cdb_idx_i] <= 1 only if valid[cdb_idx_i]; otherwise ignored. A CDB hit on an entry freed that same edge is ignored.
- Retire condition R = valid[head] & done[head] & ~commit_stall_i, evaluated combinationally from current state. When R holds, at the edge:
  - valid[head] <= 0, done[head] <= 0, head <= head+1 (wrapping).
  - commit_en_o <= 1; commit_rd_addr_o <= rd; commit_prd_o <= prd.
  - free_en_o <= has_rd & (old_prd != 0); free_addr_o <= old_prd. Physical reg 0 is never freed.
- When R does not hold: commit_en_o <= 0 and free_en_o <= 0; the data outputs hold their last values.
- Maximum rate: one retire per cycle.
- Latency: CDB at edge N marks done. If that entry is head, R is true during cycle N..N+1, it retires at edge N+1, and commit_en_o/free_en_o are high during the following cycle.
- Count update: alloc only → +1; retire only → -1; both → unchanged; neither → unchanged.
- Same-cycle alloc and retire on the same slot (full→retire) cannot happen because of the no-bypass rule. When count = 0, head == tail and nothing retires.
- An empty buffer with cdb_en_i set does not change state.

Test Plan:
- Reset, then alloc 3 entries (rd=1/2/3, prd=1/2/3, old=0/0/0, has_rd=1); CDB idx 0,1,2 on consecutive cycles → commit_en_o pulses 3 consecutive cycles, prd 1,2,3 in order; free_en_o stays 0 (old_prd=0); count_o returns to 0.
- Out-of-order completion: alloc A(idx0, old=5), B(idx1, old=6); CDB idx1 then idx0 → nothing retires until idx0 done; then A retires (free_addr_o=5) and B retires the next cycle (free_addr_o=6).
- Fill 16 entries → alloc_ready_o=0, count_o=16. A 17th alloc_en_i is ignored. Complete head → one retire; alloc_ready_o=1 the cycle after, and alloc_idx_o=0 (wrap).
- commit_stall_i high while head done for 4 cycles → no commit_en_o. Deassert → retire on the next edge, pulse one cycle later.
- CDB to an invalid index (e.g. idx 7 with count=2) → no state change; later alloc to idx 7 starts with done=0 and does not retire without its own CDB.
- Assert reset_i low asynchronously mid-run with 5 entries in flight → outputs go to reset values immediately; no free_en_o pulses after release; first alloc gets alloc_idx_o=0.

Source files
------------

// File: rtl/rob_commit_if.sv
// Rename/CDB/commit bundle for the in-order retire buffer.
// Latency: n/a (wires only). master = rename/CDB/free-list side, slave = rob_commit.
// Backpressure: alloc_ready_o gates alloc_en_i; commit_stall_i holds retirement.
// Ports: alloc_* (push one rename result), cdb_* (completion), commit_*/free_* (retire outputs),
//        count_o/empty_o (occupancy).
interface rob_commit_if #(
  parameter int IDXW = 4
);
  logic            alloc_en_i;
  logic            alloc_has_rd_i;
  logic [4:0]      alloc_rd_addr_i;
  logic [4:0]      alloc_prd_i;
  logic [4:0]      alloc_old_prd_i;
  logic            alloc_ready_o;
  logic [IDXW-1:0] alloc_idx_o;
  logic            cdb_en_i;
  logic [IDXW-1:0] cdb_idx_i;
  logic            commit_stall_i;
  logic            commit_en_o;
  logic [4:0]      commit_rd_addr_o;
  logic [4:0]      commit_prd_o;
  logic            free_en_o;
  logic [4:0]      free_addr_o;
  logic [IDXW:0]   count_o;
  logic            empty_o;

  modport master (
    output alloc_en_i, alloc_has_rd_i, alloc_rd_addr_i, alloc_prd_i, alloc_old_prd_i,
    output cdb_en_i, cdb_idx_i, commit_stall_i,
    input  alloc_ready_o, alloc_idx_o, commit_en_o, commit_rd_addr_o, commit_prd_o,
    input  free_en_o, free_addr_o, count_o, empty_o
  );

  modport slave (
    input  alloc_en_i, alloc_has_rd_i, alloc_rd_addr_i, alloc_prd_i, alloc_old_prd_i,
    input  cdb_en_i, cdb_idx_i, commit_stall_i,
    output alloc_ready_o, alloc_idx_o, commit_en_o, commit_rd_addr_o, commit_prd_o,
    output free_en_o, free_addr_o, count_o, empty_o
  );
endinterface

// File: rtl/rob_commit.sv
// In-order retire buffer: records rename allocations, marks them done from the CDB,
// retires in program order and returns the displaced physical register to the free list.
// Latency: CDB at edge N on the head entry -> retire at edge N+1 -> commit/free pulse the cycle after.
// Backpressure: alloc refused while full (no same-cycle retire bypass); commit_stall_i holds retirement.
// Ports: clk_i, reset_i (async active-low), bus (rob_commit_if.slave).
module rob_commit #(
  parameter int DEPTH = 16,
  parameter int IDXW  = 4
) (
  input logic         clk_i,
  input logic         reset_i,
  rob_commit_if.slave bus
);

  localparam logic [IDXW:0] FULL_CNT = (IDXW + 1)'(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] has_rd_q;
  logic [4:0]       rd_q      [DEPTH];
  logic [4:0]       prd_q     [DEPTH];
  logic [4:0]       old_prd_q [DEPTH];

  logic [IDXW-1:0]  head_q;
  logic [IDXW-1:0]  tail_q;
  logic [IDXW:0]    count_q;

  logic             commit_en_q;
  logic [4:0]       commit_rd_q;
  logic [4:0]       commit_prd_q;
  logic             free_en_q;
  logic [4:0]       free_addr_q;

  logic             alloc_ready;
  logic             alloc_fire;
  logic             retire;
  logic             cdb_hit;

  assign alloc_ready = (count_q < FULL_CNT);
  assign alloc_fire  = bus.alloc_en_i & alloc_ready;
  assign retire      = valid_q[head_q] & done_q[head_q] & ~bus.commit_stall_i;
  assign cdb_hit     = bus.cdb_en_i & valid_q[bus.cdb_idx_i];

  // Payload is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      has_rd_q[tail_q]  <= bus.alloc_has_rd_i;
      rd_q[tail_q]      <= bus.alloc_rd_addr_i;
      prd_q[tail_q]     <= bus.alloc_prd_i;
      old_prd_q[tail_q] <= bus.alloc_old_prd_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q      <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_en_q  <= 1'b0;
      commit_rd_q  <= '0;
      commit_prd_q <= '0;
      free_en_q    <= 1'b0;
      free_addr_q  <= '0;
    end else begin
      if (cdb_hit) begin
        done_q[bus.cdb_idx_i] <= 1'b1;
      end
      // Alloc only ever targets an invalid slot (tail != head unless empty, and
      // nothing retires when empty), so it cannot collide with the retire clear.
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      // Placed after the CDB update so a completion aimed at the retiring slot is dropped.
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
        commit_rd_q     <= rd_q[head_q];
        commit_prd_q    <= prd_q[head_q];
        free_addr_q     <= old_prd_q[head_q];
      end
      commit_en_q <= retire;
      // Physical register 0 is hardwired and never returns to the free list.
      free_en_q   <= retire & has_rd_q[head_q] & (old_prd_q[head_q] != 5'd0);

      unique case ({alloc_fire, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.alloc_ready_o    = alloc_ready;
  assign bus.alloc_idx_o      = tail_q;
  assign bus.commit_en_o      = commit_en_q;
  assign bus.commit_rd_addr_o = commit_rd_q;
  assign bus.commit_prd_o     = commit_prd_q;
  assign bus.free_en_o        = free_en_q;
  assign bus.free_addr_o      = free_addr_q;
  assign bus.count_o          = count_q;
  assign bus.empty_o          = (count_q == '0);

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;
  localparam int DEPTH = 16;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  rob_commit_if #(.IDXW(4)) bus();

  rob_commit #(.DEPTH(DEPTH), .IDXW(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    int idx; bit has_rd; int rd; int prd; int old; bit done;
  } ent_t;
  typedef struct {
    int cyc; int rd; int prd; bit fen; int faddr;
  } exp_t;

  ent_t mq[$];   // in-flight instructions, program order
  exp_t eq[$];   // expected commit pulses
  int   m_tail = 0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a commit.
  always @(negedge clk_i) begin
    if (reset_i) begin
      if (eq.size() > 0 && eq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missed_commit: no commit seen, expected at cycle %0d (now %0d)", eq[0].cyc, cyc);
        void'(eq.pop_front());
      end
      if (bus.commit_en_o === 1'b1) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: commit_en_o=1 with nothing expected (cycle %0d)", cyc);
        end else begin
          mon_e = eq.pop_front();
          chk("commit_cycle", cyc, mon_e.cyc);
          chk("commit_rd_addr", bus.commit_rd_addr_o, mon_e.rd);
          chk("commit_prd", bus.commit_prd_o, mon_e.prd);
          chk("free_en", bus.free_en_o, mon_e.fen);
          chk("free_addr", bus.free_addr_o, mon_e.faddr);
        end
      end else if (bus.free_en_o !== 1'b0) begin
        checks++; errors++;
        $display("FAIL free_without_commit: free_en_o=%b commit_en_o=%b", bus.free_en_o, bus.commit_en_o);
      end
    end
  end

  // One clock of stimulus; also compares the occupancy outputs against the model.
  task automatic step(bit a_en, bit hr, int rd, int prd, int old, bit c_en, int c_idx, bit stall);
    bit   rdy;
    bit   ret;
    ent_t h;
    @(posedge clk_i); #1;
    chk("count_o", bus.count_o, mq.size());
    chk("alloc_ready_o", bus.alloc_ready_o, mq.size() < DEPTH);
    chk("alloc_idx_o", bus.alloc_idx_o, m_tail);
    chk("empty_o", bus.empty_o, mq.size() == 0);
    bus.alloc_en_i      = a_en;
    bus.alloc_has_rd_i  = hr;
    bus.alloc_rd_addr_i = 5'(rd);
    bus.alloc_prd_i     = 5'(prd);
    bus.alloc_old_prd_i = 5'(old);
    bus.cdb_en_i        = c_en;
    bus.cdb_idx_i       = 4'(c_idx);
    bus.commit_stall_i  = stall;
    rdy = mq.size() < DEPTH;
    ret = mq.size() > 0 && mq[0].done && !stall;
    if (c_en) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].idx == c_idx) begin
          h = mq[i]; h.done = 1'b1; mq[i] = h;
        end
      end
    end
    if (ret) begin
      h = mq.pop_front();
      eq.push_back('{cyc + 1, h.rd, h.prd, h.has_rd && h.old != 0, h.old});
    end
    if (a_en && rdy) begin
      mq.push_back('{m_tail, hr, rd, prd, old, 1'b0});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(bit hr, int rd, int prd, int old);
    step(1, hr, rd, prd, old, 0, 0, 0);
  endtask

  task automatic cdb(int idx, bit stall);
    step(0, 0, 0, 0, 0, 1, idx, stall);
  endtask

  // Completes whatever is outstanding, one CDB per cycle, bounded.
  task automatic drain();
    int pick;
    for (int n = 0; n < 200 && mq.size() > 0; n++) begin
      pick = -1;
      for (int i = 0; i < mq.size(); i++)
        if (pick < 0 && !mq[i].done) pick = mq[i].idx;
      if (pick >= 0) cdb(pick, 0);
      else idle(1);
    end
    idle(3);
  endtask

  task automatic rand_steps(int n);
    int ci;
    for (int i = 0; i < n; i++) begin
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        ci = mq[$urandom_range(0, mq.size() - 1)].idx;
      else
        ci = $urandom_range(0, DEPTH - 1);
      step($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 31),
           $urandom_range(0, 31), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31),
           $urandom_range(0, 9) < 7, ci, $urandom_range(0, 6) == 0);
    end
  endtask

  task automatic reset_vals(string tag);
    chk({tag, "_commit_en"}, bus.commit_en_o, 0);
    chk({tag, "_free_en"}, bus.free_en_o, 0);
    chk({tag, "_commit_rd"}, bus.commit_rd_addr_o, 0);
    chk({tag, "_commit_prd"}, bus.commit_prd_o, 0);
    chk({tag, "_free_addr"}, bus.free_addr_o, 0);
    chk({tag, "_alloc_ready"}, bus.alloc_ready_o, 1);
    chk({tag, "_alloc_idx"}, bus.alloc_idx_o, 0);
    chk({tag, "_count"}, bus.count_o, 0);
    chk({tag, "_empty"}, bus.empty_o, 1);
  endtask

  task automatic clear_inputs();
    bus.alloc_en_i      = 1'b0;
    bus.alloc_has_rd_i  = 1'b0;
    bus.alloc_rd_addr_i = '0;
    bus.alloc_prd_i     = '0;
    bus.alloc_old_prd_i = '0;
    bus.cdb_en_i        = 1'b0;
    bus.cdb_idx_i       = '0;
    bus.commit_stall_i  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a_idx;
    int b_idx;
    clear_inputs();
    #12;
    reset_vals("reset");
    reset_i = 1'b1;

    // In-order completion, old_prd = 0 so nothing is freed.
    alloc(1, 1, 1, 0); alloc(1, 2, 2, 0); alloc(1, 3, 3, 0);
    cdb(0, 0); cdb(1, 0); cdb(2, 0);
    idle(4);

    // Out-of-order completion: younger done first, nothing retires until the head is done.
    a_idx = m_tail; alloc(1, 10, 20, 5);
    b_idx = m_tail; alloc(1, 11, 21, 6);
    cdb(b_idx, 0); idle(3);
    cdb(a_idx, 0); idle(4);

    // Fill, refused extra alloc, then retire one and watch tail wrap.
    while (mq.size() < DEPTH) alloc(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31));
    alloc(1, 31, 31, 31);
    cdb(mq[0].idx, 0); idle(3);
    alloc(1, 4, 4, 4);
    drain();

    // Stall while the head is done.
    alloc(1, 7, 8, 9);
    cdb(mq[0].idx, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // CDB to an idle slot is ignored; the later entry in that slot needs its own CDB.
    alloc(1, 1, 2, 3); alloc(1, 4, 5, 6);
    a_idx = (m_tail + 5) % DEPTH;
    cdb(a_idx, 0);
    while (mq.size() < 8) alloc(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
    for (int i = 0; i < 2; i++) cdb(mq[0].idx, 0);
    idle(4);
    drain();

    rand_steps(3000);
    drain();

    // Asynchronous reset with five entries in flight.
    for (int i = 0; i < 5; i++) alloc(1, i + 1, i + 2, i + 3);
    cdb(mq[0].idx, 0); cdb(mq[1].idx, 0);
    @(negedge clk_i); #1;
    reset_i = 1'b0;
    clear_inputs();
    mq.delete(); eq.delete(); m_tail = 0;
    #1;
    reset_vals("midreset");
    @(posedge clk_i); #2;
    reset_vals("midreset_hold");
    reset_i = 1'b1;
    idle(5);
    alloc(1, 9, 9, 9);
    idle(2);
    rand_steps(500);
    drain();

    chk("scoreboard_empty", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
